qic117_segment_reader: RTL and testbench

QIC117_SEGMENT_READER -- requirements
Module: qic117_segment_reader

---
 rtl/qic117_segment_reader_if.sv | 36 +++
 rtl/qic117_segment_reader.sv | 151 +++++++++++++++
 tb/tb_qic117_segment_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qic117_segment_reader_if.sv
// Command, tape-FSM and data-streamer signals of the QIC-117 segment reader.
// The master drives commands and streamer strobes. The slave is the reader.
interface qic117_segment_reader_if;
  logic        cmd_start;
  logic [15:0] cmd_count;
  logic        cmd_abort;
  logic        tape_ready;
  logic        seg_start;
  logic        blk_complete;
  logic        seg_complete;
  logic        sync_lost;
  logic        file_mark;
  logic        tape_stream_req;
  logic        streamer_en;
  logic        busy;
  logic        done;
  logic        fail;
  logic [2:0]  err_code;
  logic [15:0] segments_done;
  logic [5:0]  blocks_seen;
  logic [1:0]  retry_cnt;

  modport master (
    output cmd_start, cmd_count, cmd_abort, tape_ready,
           seg_start, blk_complete, seg_complete, sync_lost, file_mark,
    input  tape_stream_req, streamer_en, busy, done, fail,
           err_code, segments_done, blocks_seen, retry_cnt
  );

  modport slave (
    input  cmd_start, cmd_count, cmd_abort, tape_ready,
           seg_start, blk_complete, seg_complete, sync_lost, file_mark,
    output tape_stream_req, streamer_en, busy, done, fail,
           err_code, segments_done, blocks_seen, retry_cnt
  );
endinterface

// File: rtl/qic117_segment_reader.sv
// QIC-117 segment reader: spins up the tape, hunts and reads segments, and retries on sync loss or timeout.
// Optional QIC_FILEMARK_STOP_EN: a file mark seen while reading ends the command with err_code 5.
module qic117_segment_reader #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int MAX_RETRY      = 3
) (
  input logic                     clk,
  input logic                     reset_n,
  qic117_segment_reader_if.slave  bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPINUP = 3'd1;
  localparam logic [2:0] HUNT   = 3'd2;
  localparam logic [2:0] READ   = 3'd3;
  localparam logic [2:0] RETRY  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] FAIL   = 3'd6;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state, state_nxt;
  logic [15:0]   count_q, count_nxt;
  logic [15:0]   seg_q, seg_nxt;
  logic [5:0]    blk_q, blk_nxt;
  logic [1:0]    retry_q, retry_nxt;
  logic [2:0]    err_q, err_nxt;
  logic [TW-1:0] timer_q;

  logic        waiting_data;
  logic        timeout;
  logic        can_retry;
  logic        fm_stop;
  logic [15:0] seg_inc;

  assign waiting_data = (state == HUNT) || (state == READ);
  assign timeout      = (timer_q == TMO_LAST);
  assign can_retry    = int'(retry_q) < MAX_RETRY;
  assign seg_inc      = seg_q + 16'd1;

`ifdef QIC_FILEMARK_STOP_EN
  assign fm_stop = bus.file_mark;
`else
  // file_mark is still read here so the port counts as used, but it has no effect.
  assign fm_stop = bus.file_mark & 1'b0;
`endif

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    seg_nxt   = seg_q;
    blk_nxt   = blk_q;
    retry_nxt = retry_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (bus.cmd_start) begin
        count_nxt = bus.cmd_count;
        seg_nxt   = '0;
        blk_nxt   = '0;
        retry_nxt = '0;
        err_nxt   = '0;
        state_nxt = (bus.cmd_count == 16'd0) ? DONE : SPINUP;
      end
      SPINUP: begin
        if (bus.cmd_abort) begin
          state_nxt = FAIL;
          err_nxt   = 3'd4;
        end else if (bus.tape_ready) begin
          state_nxt = HUNT;
        end else if (timeout) begin
          state_nxt = FAIL;
          err_nxt   = 3'd1;
        end
      end
      HUNT, READ: begin
        if (bus.cmd_abort) begin
          state_nxt = FAIL;
          err_nxt   = 3'd4;
        end else if (state == READ && fm_stop) begin
          state_nxt = FAIL;
          err_nxt   = 3'd5;
        end else if (state == READ && bus.seg_complete) begin
          // A block arriving with seg_complete is subsumed: blocks_seen restarts at 0 anyway.
          seg_nxt   = seg_inc;
          blk_nxt   = '0;
          retry_nxt = '0;
          state_nxt = (seg_inc == count_q) ? DONE : HUNT;
        end else if (bus.sync_lost || timeout) begin
          if (can_retry) begin
            retry_nxt = retry_q + 2'd1;
            blk_nxt   = '0;
            state_nxt = RETRY;
          end else begin
            state_nxt = FAIL;
            err_nxt   = bus.sync_lost ? 3'd3 : 3'd2;
          end
        end else if (state == HUNT && bus.seg_start) begin
          state_nxt = READ;
        end else if (state == READ && bus.blk_complete && blk_q != 6'd32) begin
          blk_nxt = blk_q + 6'd1;
        end
      end
      RETRY: begin
        if (bus.cmd_abort) begin
          state_nxt = FAIL;
          err_nxt   = 3'd4;
        end else begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count_q <= '0;
      seg_q   <= '0;
      blk_q   <= '0;
      retry_q <= '0;
      err_q   <= '0;
      timer_q <= '0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      seg_q   <= seg_nxt;
      blk_q   <= blk_nxt;
      retry_q <= retry_nxt;
      err_q   <= err_nxt;
      // The timer measures time since the last sign of progress in SPINUP/HUNT/READ.
      if (state_nxt != state || !(state == SPINUP || waiting_data) ||
          (waiting_data && (bus.seg_start || bus.blk_complete)))
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;
    end
  end

  assign bus.tape_stream_req = (state == SPINUP) || waiting_data || (state == RETRY);
  assign bus.streamer_en     = waiting_data;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.fail            = (state == FAIL);
  assign bus.err_code        = err_q;
  assign bus.segments_done   = seg_q;
  assign bus.blocks_seen     = blk_q;
  assign bus.retry_cnt       = retry_q;
endmodule

// File: tb/tb_qic117_segment_reader.sv
// Directed bench for qic117_segment_reader with a short timeout, so timeout paths finish quickly.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
module tb_qic117_segment_reader;
  localparam int T  = 200;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  qic117_segment_reader_if bus ();

  qic117_segment_reader #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] n);
    bus.cmd_count = n;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic do_segment(input int nblk);
    bus.seg_start = 1'b1;
    tick();
    bus.seg_start = 1'b0;
    for (int i = 0; i < nblk; i++) begin
      bus.blk_complete = 1'b1;
      tick();
      bus.blk_complete = 1'b0;
      tick();
    end
  endtask

  task automatic finish_seg();
    bus.seg_complete = 1'b1;
    tick();
    bus.seg_complete = 1'b0;
  endtask

  initial begin
    bus.cmd_start = 0; bus.cmd_count = 0; bus.cmd_abort = 0; bus.tape_ready = 0;
    bus.seg_start = 0; bus.blk_complete = 0; bus.seg_complete = 0;
    bus.sync_lost = 0; bus.file_mark = 0;

    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_tsr", bus.tape_stream_req, 0);
    check("rst_err", bus.err_code, 0);
    check("rst_segs", bus.segments_done, 0);
    check("rst_done_fail", {bus.done, bus.fail, bus.streamer_en}, 0);
    reset_n = 1'b1;
    tick();

    // Two segments; tape ready after 100 cycles; 33 blocks in segment 1 hits saturation.
    start(2);
    check("spin_tsr", bus.tape_stream_req, 1);
    check("spin_sen", bus.streamer_en, 0);
    repeat (99) tick();
    bus.tape_ready = 1'b1;
    tick();
    check("hunt_sen", bus.streamer_en, 1);
    do_segment(32);
    check("seg0_blocks", bus.blocks_seen, 32);
    finish_seg();
    check("seg0_segs", bus.segments_done, 1);
    check("seg0_blk_clr", bus.blocks_seen, 0);
    check("seg0_busy", bus.busy, 1);
    do_segment(33);
    check("blk_saturate", bus.blocks_seen, 32);
    finish_seg();
    check("ok_done", bus.done, 1);
    check("ok_segs", bus.segments_done, 2);
    check("ok_err", bus.err_code, 0);
    tick();
    check("ok_idle", {bus.done, bus.busy}, 0);

    // Spin-up timeout: fail exactly T cycles after SPINUP entry.
    bus.tape_ready = 1'b0;
    start(1);
    repeat (T - 1) tick();
    check("spin_not_yet", bus.fail, 0);
    check("spin_tsr_hold", bus.tape_stream_req, 1);
    tick();
    check("spin_fail", bus.fail, 1);
    check("spin_err", bus.err_code, 1);
    check("spin_tsr_drop", bus.tape_stream_req, 0);
    tick();
    check("spin_err_hold", {bus.fail, bus.busy, bus.err_code}, 3'd1);
    bus.tape_ready = 1'b1;

    // Sync lost four times with MAX_RETRY=3.
    start(1);
    tick();
    do_segment(3);
    check("sl_blocks", bus.blocks_seen, 3);
    for (int k = 1; k <= 3; k++) begin
      bus.sync_lost = 1'b1;
      tick();
      bus.sync_lost = 1'b0;
      check("sl_retry_sen", {bus.streamer_en, bus.tape_stream_req}, 2'b01);
      check("sl_retry_cnt", bus.retry_cnt, k);
      check("sl_retry_blk", bus.blocks_seen, 0);
      tick();
      check("sl_back_hunt", bus.streamer_en, 1);
      do_segment(1);
    end
    bus.sync_lost = 1'b1;
    tick();
    bus.sync_lost = 1'b0;
    check("sl_fail", bus.fail, 1);
    check("sl_err", bus.err_code, 3);
    tick();

    // Block timeouts in HUNT exhaust the retries.
    start(1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      repeat (T - 1) tick();
      check("to_still_hunt", bus.streamer_en, 1);
      tick();
      check("to_retry", {bus.streamer_en, bus.retry_cnt}, k);
      tick();
    end
    repeat (T) tick();
    check("to_fail", bus.fail, 1);
    check("to_err", bus.err_code, 2);
    tick();

    // Abort at block 10 of segment 1, then a normal command.
    start(2);
    tick();
    do_segment(5);
    finish_seg();
    do_segment(10);
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    check("ab_fail", bus.fail, 1);
    check("ab_err", bus.err_code, 4);
    check("ab_blocks", bus.blocks_seen, 10);
    check("ab_tsr", bus.tape_stream_req, 0);
    check("ab_segs", bus.segments_done, 1);
    tick();
    start(1);
    check("ab_err_clr", bus.err_code, 0);
    tick();
    do_segment(2);
    finish_seg();
    check("ab_next_done", bus.done, 1);
    tick();

    // Zero-length command.
    start(0);
    check("zero_done", bus.done, 1);
    check("zero_tsr", bus.tape_stream_req, 0);
    tick();
    check("zero_idle", bus.busy, 0);

    // seg_complete, sync_lost and blk_complete together: the segment is counted and no retry is taken.
    start(1);
    tick();
    do_segment(1);
    bus.seg_complete = 1'b1; bus.sync_lost = 1'b1; bus.blk_complete = 1'b1;
    tick();
    bus.seg_complete = 1'b0; bus.sync_lost = 1'b0; bus.blk_complete = 1'b0;
    check("both_done", bus.done, 1);
    check("both_retry", bus.retry_cnt, 0);
    check("both_segs", bus.segments_done, 1);
    tick();

    // cmd_start while busy is ignored.
    start(1);
    tick();
    bus.cmd_count = 16'd5;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    do_segment(1);
    finish_seg();
    check("busy_start_done", {bus.done, bus.segments_done}, {1'b1, 16'd1});
    tick();

    // File mark in segment 0.
    start(1);
    tick();
    do_segment(2);
    bus.file_mark = 1'b1;
    tick();
    bus.file_mark = 1'b0;
`ifdef QIC_FILEMARK_STOP_EN
    check("fm_fail", bus.fail, 1);
    check("fm_err", bus.err_code, 5);
    check("fm_segs", bus.segments_done, 0);
`else
    check("fm_ignored", {bus.busy, bus.fail}, 2'b10);
    do_segment(1);
    finish_seg();
    check("fm_done", bus.done, 1);
    check("fm_err", bus.err_code, 0);
`endif
    tick();

    // Asynchronous reset mid-operation.
    start(1);
    tick();
    do_segment(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_blocks", bus.blocks_seen, 0);
    check("arst_tsr", {bus.tape_stream_req, bus.streamer_en}, 0);
    #2;
    reset_n = 1'b1;
    tick();
    check("arst_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
